nibble_cmp_seq: RTL and testbench

//  Sequential wide-word magnitude comparator. Accepts two WIDTH-bit operands over a

---
 rtl/nibble_cmp_pkg.sv | 18 +
 rtl/nib_cmp4.sv | 14 +
 rtl/nibble_cmp_seq.sv | 132 +++++++++++++
 tb/tb_nibble_cmp_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_cmp_pkg.sv
// Shared types for the nibble-serial magnitude comparator.
package nibble_cmp_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } verdict_t;

endpackage

// File: rtl/nib_cmp4.sv
// Combinational 4-bit unsigned magnitude comparator slice.
module nib_cmp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/nibble_cmp_seq.sv
// Sequential wide-word comparator: one nibble per cycle, MSB first, valid/ready in and out.
// Define NIBBLE_CMP_EARLY_EXIT_EN to finish the scan at the first differing nibble.
module nibble_cmp_seq
  import nibble_cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx;
  logic             decided;
  logic             gt_q;
  logic             lt_q;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  verdict_t         slice;
  logic             gt_n;
  logic             lt_n;
  logic             scan_last;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_q[i*NIB_W +: NIB_W];
        b_nib = b_q[i*NIB_W +: NIB_W];
      end
    end
  end

  nib_cmp4 u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .gt (slice.gt),
    .lt (slice.lt),
    .eq (slice.eq)
  );

  // Once a nibble has differed, later (lower) nibbles cannot alter the verdict.
  always_comb begin
    gt_n = decided ? gt_q : slice.gt;
    lt_n = decided ? lt_q : slice.lt;
`ifdef NIBBLE_CMP_EARLY_EXIT_EN
    scan_last = (idx == '0) || (!decided && !slice.eq);
`else
    scan_last = (idx == '0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_gt_b    <= 1'b0;
      a_lt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
      busy      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      idx       <= '0;
      decided   <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            idx      <= IDX_W'(NIB - 1);
            decided  <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          gt_q    <= gt_n;
          lt_q    <= lt_n;
          decided <= decided | ~slice.eq;
          if (scan_last) begin
            out_valid <= 1'b1;
            a_gt_b    <= gt_n;
            a_lt_b    <= lt_n;
            a_eq_b    <= ~gt_n & ~lt_n;
            state     <= S_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            a_gt_b    <= 1'b0;
            a_lt_b    <= 1'b0;
            a_eq_b    <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_cmp_seq.sv
// Directed self-checking bench for nibble_cmp_seq (WIDTH=16), both scan configurations.
module tb_nibble_cmp_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic        a_gt_b;
  logic        a_lt_b;
  logic        a_eq_b;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef NIBBLE_CMP_EARLY_EXIT_EN
  localparam int LAT_MSB = 2;
`else
  localparam int LAT_MSB = 5;
`endif
  localparam int LAT_FULL = 5;

  nibble_cmp_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_gt_b    (a_gt_b),
    .a_lt_b    (a_lt_b),
    .a_eq_b    (a_eq_b),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a/b at a negedge; returns just after the accepting rising edge.
  task automatic accept(input string tag, input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, int'(busy), 1);
  endtask

  // Latency counts the accept edge as cycle 0: out_valid first seen after edge n is cycle n+1.
  task automatic wait_verdict(input string tag, input int lat, input bit g, input bit l, input bit e);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_out_valid"}, int'(out_valid), 1);
    check({tag, "_latency"}, n + 1, lat);
    check({tag, "_gt"}, int'(a_gt_b), int'(g));
    check({tag, "_lt"}, int'(a_lt_b), int'(l));
    check({tag, "_eq"}, int'(a_eq_b), int'(e));
  endtask

  task automatic release_check(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_ov_drop"}, int'(out_valid), 0);
    check({tag, "_ready_back"}, int'(in_ready), 1);
    check({tag, "_idle_eq"}, int'(a_eq_b), 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_gt", int'(a_gt_b), 0);
    check("rst_lt", int'(a_lt_b), 0);
    check("rst_eq", int'(a_eq_b), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: equal operands always scan every nibble
    accept("t1", 16'h1234, 16'h1234);
    wait_verdict("t1", LAT_FULL, 1'b0, 1'b0, 1'b1);
    release_check("t1");

    // 2: differs at MSB nibble
    accept("t2", 16'h8000, 16'h7FFF);
    wait_verdict("t2", LAT_MSB, 1'b1, 1'b0, 1'b0);
    release_check("t2");

    // 3: differs only at LSB nibble
    accept("t3", 16'h1230, 16'h1231);
    wait_verdict("t3", LAT_FULL, 1'b0, 1'b1, 1'b0);
    release_check("t3");

    // 4: back-pressure holds the verdict; in_valid while busy is ignored
    @(negedge clk);
    out_ready = 1'b0;
    accept("t4", 16'h8000, 16'h7FFF);
    wait_verdict("t4", LAT_MSB, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a        = 16'h0000;
        b        = 16'h0001;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("t4_hold_ov", int'(out_valid), 1);
      check("t4_hold_gt", int'(a_gt_b), 1);
      check("t4_hold_lt", int'(a_lt_b), 0);
      check("t4_hold_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("t4_release_gt", int'(a_gt_b), 1);
    release_check("t4");
    repeat (6) @(posedge clk);
    #1;
    check("t4_no_queue_ov", int'(out_valid), 0);
    check("t4_no_queue_busy", int'(busy), 0);

    // 5: reset in the middle of SCAN drops the transaction
    accept("t5", 16'h4321, 16'h1234);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_ov", int'(out_valid), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_gt", int'(a_gt_b), 0);
    check("t5_rst_lt", int'(a_lt_b), 0);
    check("t5_rst_eq", int'(a_eq_b), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_ready_after", int'(in_ready), 1);
    check("t5_no_verdict", int'(out_valid), 0);
    accept("t5b", 16'h0001, 16'h0001);
    wait_verdict("t5b", LAT_FULL, 1'b0, 1'b0, 1'b1);
    release_check("t5b");

    // 6: back-to-back with in_valid held high
    @(negedge clk);
    a        = 16'hFFFF;
    b        = 16'h0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("t6a_busy", int'(busy), 1);
    a = 16'h0000;
    b = 16'hFFFF;
    wait_verdict("t6a", LAT_MSB, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("t6_idle_ready", int'(in_ready), 1);
    check("t6_idle_ov", int'(out_valid), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("t6b_accept_ready", int'(in_ready), 0);
    check("t6b_busy", int'(busy), 1);
    wait_verdict("t6b", LAT_MSB, 1'b0, 1'b1, 1'b0);
    release_check("t6b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
